// File: rtl/piezo_phase_array.sv
// piezo_phase_array: NUM_CH phase-offset square-wave drivers with double-buffered Avalon-MM settings.
// Optional PIEZO_CH_MASK_EN adds committed per-channel enable mask words at 0xF0+w.
module piezo_phase_array #(
    parameter int NUM_CH         = 89,
    parameter int CNT_W          = 11,
    parameter int DEFAULT_PERIOD = 1250
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        avs_address,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] piezo_out,
    output logic              piezo_enable,
    output logic [2:0]        piezo_status,
    output logic              cycle_start
);
    localparam int               NUM_MW   = (NUM_CH + 31) / 32;
    localparam logic [CNT_W-1:0] RST_P    = CNT_W'(DEFAULT_PERIOD - 1);
    localparam logic [CNT_W-1:0] RST_D    = CNT_W'(DEFAULT_PERIOD / 2);
    localparam logic [7:0]       A_CTRL   = 8'h00;
    localparam logic [7:0]       A_PERIOD = 8'h01;
    localparam logic [7:0]       A_DUTY   = 8'h02;
    localparam logic [7:0]       A_STATUS = 8'h03;
    localparam logic [7:0]       A_PHASE  = 8'h04;
    localparam logic [7:0]       A_MASK   = 8'hF0;

    // Assertion clears the synchroniser at once; release reaches the core after two edges.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic              ctrl_en, running, pending, error;
    logic [CNT_W-1:0]  cnt, p_sh, d_sh, p_act, d_act;
    logic [CNT_W-1:0]  ph_sh  [NUM_CH];
    logic [CNT_W-1:0]  ph_act [NUM_CH];
    logic [NUM_CH-1:0] ch_en, wave;
    logic [31:0]       rd_mux;
    logic              wr_ctrl, wr_status, commit_req, wrap, do_copy, ph_hit, ph_ok;

    assign wr_ctrl    = avs_write && (avs_address == A_CTRL);
    assign wr_status  = avs_write && (avs_address == A_STATUS);
    assign commit_req = wr_ctrl && avs_writedata[1];
    assign wrap       = running && (cnt >= p_act);
    // Running: copy only at the wrap (a commit landing on the wrap counts). Idle: one cycle after commit.
    assign do_copy    = running ? ((pending || commit_req) && wrap) : pending;
    assign ph_hit     = avs_write && (int'(avs_address) >= 4) && (int'(avs_address) < 4 + NUM_CH);
    assign ph_ok      = avs_writedata <= 32'(p_sh);

`ifdef PIEZO_CH_MASK_EN
    logic [NUM_MW*32-1:0] mask_sh;
    logic [NUM_CH-1:0]    mask_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_sh  <= '1;
            mask_act <= '1;
        end else begin
            for (int w = 0; w < NUM_MW; w++)
                if (avs_write && avs_address == 8'(A_MASK + w))
                    mask_sh[w*32 +: 32] <= avs_writedata;
            if (do_copy) mask_act <= mask_sh[NUM_CH-1:0];
        end
    end
    assign ch_en = mask_act;
`else
    assign ch_en = '1;
`endif

    // Circular distance from the channel's phase point; constant-low/high duty fall out naturally.
    function automatic logic wave_bit(input logic [CNT_W-1:0] c, phi, p, d);
        logic [CNT_W:0] diff;
        if (c >= phi) diff = {1'b0, c} - {1'b0, phi};
        else          diff = {1'b0, c} + {1'b0, p} + (CNT_W+1)'(1) - {1'b0, phi};
        return diff < {1'b0, d};
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wave = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            wave[ch] = wave_bit(cnt, ph_act[ch], p_act, d_act) & ch_en[ch];
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_CTRL:   rd_mux = {31'b0, ctrl_en};
            A_PERIOD: rd_mux = 32'(p_sh);
            A_DUTY:   rd_mux = 32'(d_sh);
            A_STATUS: rd_mux = {29'b0, error, pending, running};
            default:  ;
        endcase
        for (int ch = 0; ch < NUM_CH; ch++)
            if (avs_address == 8'(A_PHASE + ch)) rd_mux = 32'(ph_sh[ch]);
`ifdef PIEZO_CH_MASK_EN
        for (int w = 0; w < NUM_MW; w++)
            if (avs_address == 8'(A_MASK + w)) rd_mux = mask_sh[w*32 +: 32];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en      <= 1'b0;
            running      <= 1'b0;
            pending      <= 1'b0;
            error        <= 1'b0;
            cnt          <= '0;
            p_sh         <= RST_P;
            p_act        <= RST_P;
            d_sh         <= RST_D;
            d_act        <= RST_D;
            // NOTE: the phase arrays are registers with a defined reset value, not RAM, so they are reset.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                ph_sh[ch]  <= '0;
                ph_act[ch] <= '0;
            end
            piezo_out    <= '0;
            cycle_start  <= 1'b0;
            avs_readdata <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (wr_ctrl)                 ctrl_en <= avs_writedata[0];
            running <= ctrl_en;

            if (!running || cnt >= p_act) cnt <= '0;
            else                          cnt <= cnt + CNT_W'(1);

            if (avs_write && avs_address == A_PERIOD) p_sh <= avs_writedata[CNT_W-1:0];
            if (avs_write && avs_address == A_DUTY)   d_sh <= avs_writedata[CNT_W-1:0];
            for (int ch = 0; ch < NUM_CH; ch++)
                if (avs_write && ph_ok && avs_address == 8'(A_PHASE + ch))
                    ph_sh[ch] <= avs_writedata[CNT_W-1:0];

            if (wr_status && avs_writedata[2]) error <= 1'b0;
            if (ph_hit && !ph_ok)              error <= 1'b1;

            if (do_copy) begin
                p_act   <= p_sh;
                d_act   <= d_sh;
                for (int ch = 0; ch < NUM_CH; ch++) ph_act[ch] <= ph_sh[ch];
                pending <= 1'b0;
            end else if (commit_req) begin
                pending <= 1'b1;
            end

            piezo_out    <= running ? wave : '0;
            cycle_start  <= running && (cnt == '0);
            avs_readdata <= avs_read ? rd_mux : '0;
        end
    end

    assign piezo_enable = running;
    assign piezo_status = {error, pending, running};
endmodule

// File: doc/piezo_phase_array.md
# piezo_phase_array

Parametrised phased-array transducer driver: the successor to the fixed 89-channel piezo controller. It generates NUM_CH square-wave drive outputs, each with its own phase offset, plus a shared period and duty. All settings go through double-buffered Avalon-MM registers and are committed atomically at the wave boundary, so the acoustic field never sees a torn update. The block sits in the FPGA fabric behind the HPS lightweight bridge and drives the transducer conduit.

## Interface
- NUM_CH, 89: number of drive channels, 1..120.
- CNT_W, 11: width of the counter, period, phase and duty fields.
- DEFAULT_PERIOD, 1250: reset drive period in clk cycles (40 kHz at 50 MHz).
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  8  word address.
- avs_write / avs_read  in  1  Avalon-MM strobes.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; fixed latency 1, no waitrequest.
- piezo_out  out  NUM_CH  registered drive outputs.
- piezo_enable  out  1  registered copy of CTRL.enable.
- piezo_status  out  3  {error, commit_pending, running}.
- cycle_start  out  1  one-cycle pulse when the counter is 0 while running.

## Operation
- Register map:
  - 0x00 CTRL: bit0 enable; bit1 commit (write-1, self-clearing, reads 0).
  - 0x01 PERIOD: shadow value P; wave period is P+1 cycles.
  - 0x02 DUTY: shadow value D, the high-cycle count.
  - 0x03 STATUS: read {error, pending, running}; writing 1 to bit2 clears error.
  - 0x04+ch: phase shadow φ[ch]. Unmapped addresses read 0 and ignore writes.
- Phase writes: a write with value > shadow P is rejected. The shadow is unchanged and error is set (sticky).
- Counter: when running, counts 0..P_act and wraps to 0. When disabled it is held at 0.
- Per-channel output:
  - diff = cnt ≥ φ ? cnt−φ : cnt+P_act+1−φ.
  - Output is high iff diff < D_act.
  - D_act = 0 gives constant low; D_act > P_act gives constant high.
- Commit:
  - Writing CTRL.commit sets pending.
  - While running, all shadows (P, D, φ, mask) copy to active on the cycle the counter wraps P_act→0; pending clears that same cycle.
  - While disabled, the copy happens on the next cycle.
  - Shadow writes that occur while pending is set are included in the copy.
  - If a commit write coincides with the wrap cycle, the copy happens at that wrap.
- Enable falling: counter resets to 0; piezo_out goes to 0 one cycle later. Active settings are kept.
- Reset state:
  - All outputs 0.
  - P = DEFAULT_PERIOD−1, D = DEFAULT_PERIOD/2 (shadow and active).
  - All φ = 0, pending/error = 0, mask all ones.

## Timing
- Register write takes effect on the clock edge of avs_write. avs_readdata is valid the cycle after avs_read.
- piezo_out and cycle_start are registered and lag the counter value by 1 cycle.
- piezo_enable and running follow CTRL.enable 1 cycle after the write. The first counter value 0 occurs in that cycle.
- Commit takes effect at the next wrap; worst case P_act+1 cycles after the write.
- Reset is asynchronous: assertion clears everything immediately, including mid-commit. Release is synchronised internally with a 2-flop synchroniser.

## Configuration
- PIEZO_CH_MASK_EN defined:
  - Adds shadowed mask words at 0xF0+w, w = 0..⌈NUM_CH/32⌉−1. Bit b masks channel 32w+b.
  - Reset value is all ones. Masks are committed like the other shadows.
  - A masked-off channel drives 0.
- Not defined: those addresses are unmapped and every channel is always enabled.

## Test plan
- Reset then enable with defaults → ch0 output high for 625 cycles, low for 625; cycle_start pulses every 1250 cycles; status = 3'b001.
- P=99, D=50, φ[1]=25, commit, enable → ch1 rises 25 cycles after ch0; both have a 100-cycle period.
- Write φ[2]=200 while shadow P=99 → φ[2] unchanged, status bit2 = 1; writing 4 to STATUS clears it.
- While running, write φ[0]=10 then commit at mid-period → ch0 timing unchanged until the wrap; pending = 1 until the wrap, then the new phase applies.
- D=0 → all outputs constant 0; D=100 with P=99 → all outputs constant 1; disable → outputs 0 within 1 cycle.
- With PIEZO_CH_MASK_EN, write 0xF0 = 0xFFFFFFFE and commit → ch0 held 0, ch1 unaffected; without the macro, a read of 0xF0 returns 0.
